axi_node_cfg_sequencer: RTL and testbench
=========================================

Name: axi_node_cfg_sequencer

Overview:
- Run-time configuration controller for the AXI node address map: routing rules (START/END per region and master port), rule-valid bits and the slave-to-master connectivity map.
- A simple req/gnt register port writes shadow tables. On a commit, the block drains the node, copies shadow to active atomically, then releases the node.
- Active tables drive the node's cfg_START_ADDR_i, cfg_END_ADDR_i, cfg_valid_rule_i and cfg_connectivity_map_i directly.

Parameters:
- N_MASTER_PORT, 8, node master ports; max 32.
- N_SLAVE_PORT, 4, node slave ports; max 128.
- N_REGION, 4, rule regions per master port; N_REGION*N_MASTER_PORT max 256, N_REGION max 128.
- TIMEOUT_W, 16, width of the drain timeout counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_req_i  in  1  register access request.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_addr_i  in  12  byte address; bits [1:0] ignored.
- cfg_wdata_i  in  32  write data.
- cfg_gnt_o  out  1  access accepted this cycle (combinational).
- cfg_rvalid_o  out  1  read data valid.
- cfg_rdata_o  out  32  read data.
- drain_req_o  out  1  node stops accepting new AW/AR.
- node_idle_i  in  1  node has no outstanding transactions.
- start_addr_o  out  N_REGION*N_MASTER_PORT*32  active START table.
- end_addr_o  out  N_REGION*N_MASTER_PORT*32  active END table.
- valid_rule_o  out  N_REGION*N_MASTER_PORT  active rule-valid table.
- connectivity_map_o  out  N_SLAVE_PORT*N_MASTER_PORT  active connectivity map.

Behaviour:
- Address decode: type = addr[11:10], idx = addr[9:2].
  - type 00 START[idx], 01 END[idx]; region = idx / N_MASTER_PORT, master = idx % N_MASTER_PORT.
  - type 10: idx < 128 gives VALID vector of region idx (bit m = master m); idx 128+s gives CONN vector of slave s.
  - type 11: word 0 CTRL, word 1 STATUS, word 2 TIMEOUT.
  - Out-of-range idx: write dropped but granted; read returns 0.
- Register fields:
  - CTRL bit0 is write-1-to-commit and reads 0.
  - STATUS, read-only: bit0 busy (FSM not IDLE), bit1 timeout_err (sticky, cleared by a write of any value to STATUS), bit2 dirty (shadow differs from active since last commit).
  - TIMEOUT holds the drain cycle limit; reset 0xFFFF (truncated to TIMEOUT_W); 0 disables the timeout.
- Reads of shadow locations return shadow values. Unused high bits read 0.
- Handshake:
  - Reads: gnt = req, always. cfg_rvalid_o pulses exactly 1 cycle after the grant, with cfg_rdata_o registered.
  - Writes to shadow/TIMEOUT/CTRL: gnt = req && state==IDLE; held off otherwise.
  - STATUS writes are always granted.
  - Requester must hold req/we/addr/wdata until gnt.
- FSM IDLE -> DRAIN -> COMMIT -> IDLE:
  - IDLE: drain_req_o=0. A granted CTRL write with bit0=1 goes to DRAIN and loads the counter with 0.
  - DRAIN: drain_req_o=1, counter increments each cycle.
    - node_idle_i=1 goes to COMMIT; the idle check has priority over the timeout in the same cycle.
    - If TIMEOUT != 0 and counter == TIMEOUT-1 with node_idle_i=0: set timeout_err, no copy, go to IDLE. drain_req_o drops on the next cycle.
  - COMMIT: drain_req_o=1 for this single cycle. All shadow tables are copied to active in this cycle, and the new values appear on outputs the next cycle. Clear dirty, go to IDLE.
  - Minimum commit latency with node_idle_i already high: CTRL write cycle, DRAIN, COMMIT, then the outputs update; 3 cycles from the write grant.
- Active outputs change only in COMMIT; no partially updated map is ever visible.
- Reset values, shadow and active alike:
  - START=0, END=0, VALID=0, CONN=all ones.
  - drain_req_o=0, cfg_rvalid_o=0, cfg_rdata_o=0.
  - state IDLE, timeout_err=0, dirty=0, TIMEOUT=all ones.
- rst during DRAIN: drain_req_o=0 next cycle, tables return to reset values, no commit.

Optional Feature:
- Macro AXI_NODE_CFG_LOCK_EN.
- When defined:
  - CTRL bit1 is a write-1 lock bit, sticky until rst. STATUS bit3 reflects it.
  - Once locked, writes to shadow tables, TIMEOUT and CTRL are granted but ignored, and no commit can start. Reads still work.
  - A CTRL write with bit0=1 and bit1=1 together commits first, and the lock takes effect after the write.
- When undefined: CTRL bit1 and STATUS bit3 read 0, writes to them have no effect, and no lock logic is present.

Test Plan:
- Reset, then read CONN[0] at addr 0x800+128*4=0xA00 -> 0x000000FF. Read START[0] -> 0. Read STATUS -> 0. valid_rule_o = 0.
- Write START[1]=0x1000_0000, END[1]=0x1FFF_FFFF, VALID[0]=0x02. Outputs stay unchanged and STATUS.dirty=1. With node_idle_i=1, write CTRL=1 -> drain_req_o high for exactly 2 cycles (DRAIN, COMMIT), outputs updated 3 cycles after the grant, dirty=0.
- TIMEOUT=10, node_idle_i=0, commit -> drain_req_o high for 10 cycles, STATUS=0x2, outputs unchanged. Write to STATUS -> STATUS=0.
- Commit with node_idle_i=0; assert node_idle_i after 5 cycles -> commit completes. A shadow write issued during DRAIN sees gnt=0 until IDLE, then lands. A STATUS read during DRAIN returns busy=1 one cycle after the grant.
- Assert rst mid-DRAIN -> drain_req_o=0 next cycle and all outputs at reset values.
- With AXI_NODE_CFG_LOCK_EN: write CTRL=0x2, then START[0]=0x5, then CTRL=1 -> START[0] reads 0, no drain_req_o, STATUS=0x8.

Source files
------------

// File: rtl/axi_node_cfg_sequencer.sv
// Shadow/active address-map tables for the AXI node with a drain-then-commit sequencer.
// Optional sticky configuration lock is built in when AXI_NODE_CFG_LOCK_EN is defined.
module axi_node_cfg_sequencer #(
  parameter int N_MASTER_PORT = 8,
  parameter int N_SLAVE_PORT  = 4,
  parameter int N_REGION      = 4,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_req_i,
  input  logic                                    cfg_we_i,
  input  logic [11:0]                             cfg_addr_i,
  input  logic [31:0]                             cfg_wdata_i,
  output logic                                    cfg_gnt_o,
  output logic                                    cfg_rvalid_o,
  output logic [31:0]                             cfg_rdata_o,
  output logic                                    drain_req_o,
  input  logic                                    node_idle_i,
  output logic [N_REGION*N_MASTER_PORT*32-1:0]    start_addr_o,
  output logic [N_REGION*N_MASTER_PORT*32-1:0]    end_addr_o,
  output logic [N_REGION*N_MASTER_PORT-1:0]       valid_rule_o,
  output logic [N_SLAVE_PORT*N_MASTER_PORT-1:0]   connectivity_map_o
);
  localparam int N_RULE = N_REGION * N_MASTER_PORT;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, COMMIT = 2'd2} state_t;

  state_t                               state_r, state_nxt_s;
  logic [TIMEOUT_W-1:0]                 cnt_r, cnt_nxt_s, timeout_r;
  logic                                 timeout_err_r, dirty_r, drain_r, tmo_hit_s, commit_s, start_s;
  logic [31:0]                          start_sh_r [N_RULE];
  logic [31:0]                          end_sh_r [N_RULE];
  logic [31:0]                          start_act_r [N_RULE];
  logic [31:0]                          end_act_r [N_RULE];
  logic [N_RULE-1:0]                    valid_sh_r, valid_act_r;
  logic [N_SLAVE_PORT*N_MASTER_PORT-1:0] conn_sh_r, conn_act_r;
  logic                                 rvalid_r;
  logic [31:0]                          rdata_r, rdata_s, status_s, idx_s;
  logic [1:0]                           type_s;
  logic                                 is_status_s, wr_acc_s, wr_start_s, wr_end_s, wr_valid_s, wr_conn_s;
  logic                                 wr_ctrl_s, wr_tmo_s, wr_status_s, wr_table_s, locked_s, addr_unused_s;

  assign type_s        = cfg_addr_i[11:10];
  assign idx_s         = {24'd0, cfg_addr_i[9:2]};
  assign addr_unused_s = ^cfg_addr_i[1:0];
  assign is_status_s   = (type_s == 2'b11) && (idx_s == 32'd1);

  // Reads and STATUS writes never stall; everything else waits for IDLE.
  assign cfg_gnt_o   = cfg_req_i && (!cfg_we_i || is_status_s || (state_r == IDLE));
  assign wr_acc_s    = cfg_req_i && cfg_we_i && (state_r == IDLE) && !locked_s;
  assign wr_start_s  = wr_acc_s && (type_s == 2'b00) && (idx_s < N_RULE);
  assign wr_end_s    = wr_acc_s && (type_s == 2'b01) && (idx_s < N_RULE);
  assign wr_valid_s  = wr_acc_s && (type_s == 2'b10) && (idx_s < N_REGION);
  assign wr_conn_s   = wr_acc_s && (type_s == 2'b10) && (idx_s >= 32'd128) && (idx_s < 32'd128 + 32'(N_SLAVE_PORT));
  assign wr_ctrl_s   = wr_acc_s && (type_s == 2'b11) && (idx_s == 32'd0);
  assign wr_tmo_s    = wr_acc_s && (type_s == 2'b11) && (idx_s == 32'd2);
  assign wr_status_s = cfg_req_i && cfg_we_i && is_status_s;
  assign wr_table_s  = wr_start_s || wr_end_s || wr_valid_s || wr_conn_s;
  assign start_s     = wr_ctrl_s && cfg_wdata_i[0];
  assign status_s    = {28'd0, locked_s, dirty_r, timeout_err_r, (state_r != IDLE)};

`ifdef AXI_NODE_CFG_LOCK_EN
  logic lock_r;
  // Sticky lock; a combined commit+lock write still starts its commit first.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r <= 1'b0;
    end else if (wr_ctrl_s && cfg_wdata_i[1]) begin
      lock_r <= 1'b1;
    end else begin
      lock_r <= lock_r;
    end
  end
  assign locked_s = lock_r;
`else
  assign locked_s = 1'b0;
`endif

  // Sequencer next state: idle check wins over the timeout in DRAIN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tmo_hit_s   = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        cnt_nxt_s = cnt_r + TIMEOUT_W'(1);
        if (node_idle_i) begin
          state_nxt_s = COMMIT;
        end else if ((timeout_r != '0) && (cnt_r == timeout_r - TIMEOUT_W'(1))) begin
          state_nxt_s = IDLE;
          tmo_hit_s   = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      COMMIT: begin
        commit_s    = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state, drain output and status/timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      drain_r       <= 1'b0;
      timeout_r     <= {TIMEOUT_W{1'b1}};
      timeout_err_r <= 1'b0;
      dirty_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      drain_r       <= (state_nxt_s != IDLE);
      timeout_r     <= wr_tmo_s ? TIMEOUT_W'(cfg_wdata_i) : timeout_r;
      timeout_err_r <= tmo_hit_s ? 1'b1 : (wr_status_s ? 1'b0 : timeout_err_r);
      dirty_r       <= commit_s ? 1'b0 : (wr_table_s ? 1'b1 : dirty_r);
    end
  end

  // Shadow tables take register writes; active tables copy them all in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RULE; i++) begin
        start_sh_r[i]  <= 32'd0;
        end_sh_r[i]    <= 32'd0;
        start_act_r[i] <= 32'd0;
        end_act_r[i]   <= 32'd0;
      end
      valid_sh_r  <= '0;
      valid_act_r <= '0;
      conn_sh_r   <= '1;
      conn_act_r  <= '1;
    end else begin
      for (int i = 0; i < N_RULE; i++) begin
        if (wr_start_s && (idx_s == 32'(i))) start_sh_r[i] <= cfg_wdata_i;
        if (wr_end_s && (idx_s == 32'(i)))   end_sh_r[i]   <= cfg_wdata_i;
        if (commit_s) begin
          start_act_r[i] <= start_sh_r[i];
          end_act_r[i]   <= end_sh_r[i];
        end
      end
      for (int r = 0; r < N_REGION; r++) begin
        if (wr_valid_s && (idx_s == 32'(r)))
          valid_sh_r[r*N_MASTER_PORT +: N_MASTER_PORT] <= cfg_wdata_i[N_MASTER_PORT-1:0];
      end
      for (int s = 0; s < N_SLAVE_PORT; s++) begin
        if (wr_conn_s && (idx_s == 32'd128 + 32'(s)))
          conn_sh_r[s*N_MASTER_PORT +: N_MASTER_PORT] <= cfg_wdata_i[N_MASTER_PORT-1:0];
      end
      if (commit_s) begin
        valid_act_r <= valid_sh_r;
        conn_act_r  <= conn_sh_r;
      end
    end
  end

  // Read mux over shadow tables and control words; out-of-range reads give zero.
  always_comb begin
    rdata_s = 32'd0;
    case (type_s)
      2'b00: for (int i = 0; i < N_RULE; i++) rdata_s = (idx_s == 32'(i)) ? start_sh_r[i] : rdata_s;
      2'b01: for (int i = 0; i < N_RULE; i++) rdata_s = (idx_s == 32'(i)) ? end_sh_r[i] : rdata_s;
      2'b10: begin
        if (idx_s < 32'd128) begin
          for (int r = 0; r < N_REGION; r++)
            for (int m = 0; m < N_MASTER_PORT; m++)
              rdata_s[m] = (idx_s == 32'(r)) ? valid_sh_r[r*N_MASTER_PORT + m] : rdata_s[m];
        end else begin
          for (int s = 0; s < N_SLAVE_PORT; s++)
            for (int m = 0; m < N_MASTER_PORT; m++)
              rdata_s[m] = (idx_s == 32'd128 + 32'(s)) ? conn_sh_r[s*N_MASTER_PORT + m] : rdata_s[m];
        end
      end
      2'b11: begin
        case (idx_s)
          32'd1:   rdata_s = status_s;
          32'd2:   rdata_s = 32'(timeout_r);
          default: rdata_s = 32'd0;
        endcase
      end
      default: rdata_s = 32'd0;
    endcase
  end

  // Read response one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      rvalid_r <= cfg_req_i && !cfg_we_i;
      rdata_r  <= (cfg_req_i && !cfg_we_i) ? rdata_s : rdata_r;
    end
  end

  assign cfg_rvalid_o       = rvalid_r;
  assign cfg_rdata_o        = rdata_r;
  assign drain_req_o        = drain_r;
  assign valid_rule_o       = valid_act_r;
  assign connectivity_map_o = conn_act_r;
  for (genvar g = 0; g < N_RULE; g++) begin : g_tables
    assign start_addr_o[g*32 +: 32] = start_act_r[g];
    assign end_addr_o[g*32 +: 32]   = end_act_r[g];
  end

endmodule

// File: tb/tb_axi_node_cfg_sequencer.sv
// Self-checking bench for axi_node_cfg_sequencer: table-level model plus directed commit scenarios.
module tb_axi_node_cfg_sequencer;
  localparam int NM = 8;
  localparam int NS = 4;
  localparam int NR = 4;
  localparam int NE = NR * NM;

  logic clk = 1'b0;
  logic rst, cfg_req, cfg_we, node_idle;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic cfg_gnt_o, cfg_rvalid_o, drain_req_o;
  logic [31:0] cfg_rdata_o;
  logic [NE*32-1:0] start_addr_o, end_addr_o;
  logic [NE-1:0] valid_rule_o;
  logic [NS*NM-1:0] connectivity_map_o;

  axi_node_cfg_sequencer #(.N_MASTER_PORT(NM), .N_SLAVE_PORT(NS), .N_REGION(NR), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .drain_req_o(drain_req_o), .node_idle_i(node_idle),
    .start_addr_o(start_addr_o), .end_addr_o(end_addr_o), .valid_rule_o(valid_rule_o),
    .connectivity_map_o(connectivity_map_o));

  always #5 clk = ~clk;

  // Model: shadow/active tables per entry, plus the expected drain_req for the current cycle.
  logic [31:0] m_sh_start [NE];
  logic [31:0] m_sh_end [NE];
  logic [31:0] m_act_start [NE];
  logic [31:0] m_act_end [NE];
  logic [7:0]  m_sh_valid [NR];
  logic [7:0]  m_act_valid [NR];
  logic [7:0]  m_sh_conn [NS];
  logic [7:0]  m_act_conn [NS];
  logic m_drain;
  logic chk_en;
  logic tbl_ok;
  int n_tests = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_sh_start[i] = 32'd0; m_sh_end[i] = 32'd0; m_act_start[i] = 32'd0; m_act_end[i] = 32'd0;
    end
    for (int i = 0; i < NR; i++) begin m_sh_valid[i] = 8'd0; m_act_valid[i] = 8'd0; end
    for (int i = 0; i < NS; i++) begin m_sh_conn[i] = 8'hFF; m_act_conn[i] = 8'hFF; end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NE; i++) begin m_act_start[i] = m_sh_start[i]; m_act_end[i] = m_sh_end[i]; end
    for (int i = 0; i < NR; i++) m_act_valid[i] = m_sh_valid[i];
    for (int i = 0; i < NS; i++) m_act_conn[i] = m_sh_conn[i];
  endfunction

  // Address-map rules: START/END idx<32; VALID region idx<4; CONN slave at idx 128..131.
  function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
    case (a[11:10])
      2'b00: if (a[9:7] == 3'd0) m_sh_start[a[6:2]] = d;
      2'b01: if (a[9:7] == 3'd0) m_sh_end[a[6:2]] = d;
      2'b10: begin
        if (a[9:4] == 6'd0) m_sh_valid[a[3:2]] = d[7:0];
        if (a[9:4] == 6'b100000) m_sh_conn[a[3:2]] = d[7:0];
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] d, input logic lands);
    int w;
    w = 0;
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    #1;
    while (cfg_gnt_o !== 1'b1 && w < 50) begin step(); #1; w++; end
    check("write_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    if (cfg_gnt_o === 1'b1 && lands) model_write(a, d);
    step();
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    #1;
    check("read_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    step();
    check("read_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    check(name, cfg_rdata_o, exp);
    cfg_req = 1'b0;
  endtask

  // Every cycle: drain_req and all four active tables against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (drain_req_o !== m_drain) begin
        n_fail++;
        $display("FAIL drain_req: got %b expected %b at %0t", drain_req_o, m_drain, $time);
      end
      tbl_ok = 1'b1;
      for (int i = 0; i < NE; i++)
        if (start_addr_o[i*32 +: 32] !== m_act_start[i] || end_addr_o[i*32 +: 32] !== m_act_end[i]) tbl_ok = 1'b0;
      for (int r = 0; r < NR; r++)
        if (valid_rule_o[r*NM +: NM] !== m_act_valid[r]) tbl_ok = 1'b0;
      for (int s = 0; s < NS; s++)
        if (connectivity_map_o[s*NM +: NM] !== m_act_conn[s]) tbl_ok = 1'b0;
      n_tests++;
      if (!tbl_ok) begin
        n_fail++;
        $display("FAIL active_tables: got valid=0x%08h conn=0x%08h start1=0x%08h, model differs at %0t",
                 valid_rule_o, connectivity_map_o, start_addr_o[63:32], $time);
      end
    end
  end

  initial begin
    chk_en = 1'b0; m_drain = 1'b0; model_reset();
    rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = 12'd0; cfg_wdata = 32'd0; node_idle = 1'b1;
    step(); step(); step();
    rst = 1'b0; chk_en = 1'b1;

    // Reset state
    check("rst_valid_rule", valid_rule_o, 32'd0);
    check("rst_conn_map", connectivity_map_o, 32'hFFFF_FFFF);
    check("rst_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
    check("rst_rdata", cfg_rdata_o, 32'd0);
    cfg_read(12'hA00, 32'h0000_00FF, "rd_conn0");
    cfg_read(12'h000, 32'd0, "rd_start0");
    cfg_read(12'hC04, 32'd0, "rd_status_rst");
    cfg_read(12'hC08, 32'h0000_FFFF, "rd_timeout_rst");
    cfg_read(12'hA10, 32'd0, "rd_conn_oor");

    // Shadow writes do not reach outputs before a commit
    cfg_write(12'h004, 32'h1000_0000, 1'b1);
    cfg_write(12'h404, 32'h1FFF_FFFF, 1'b1);
    cfg_write(12'h800, 32'h0000_0002, 1'b1);
    cfg_write(12'hA04, 32'h0000_000F, 1'b1);
    cfg_write(12'h0A0, 32'hDEAD_BEEF, 1'b1);
    cfg_read(12'h0A0, 32'd0, "rd_start_oor");
    cfg_read(12'h004, 32'h1000_0000, "rd_shadow_start1");
    cfg_read(12'hC04, 32'h0000_0004, "rd_status_dirty");
    check("pre_commit_start1", start_addr_o[63:32], 32'd0);

    // Commit with node already idle: drain 2 cycles, outputs 3 cycles after grant
    cfg_write(12'hC00, 32'd1, 1'b0);
    m_drain = 1'b1; step();
    check("commit_not_early", start_addr_o[63:32], 32'd0);
    m_drain = 1'b1; step();
    m_drain = 1'b0; model_commit();
    check("commit_start1", start_addr_o[63:32], 32'h1000_0000);
    check("commit_end1", end_addr_o[63:32], 32'h1FFF_FFFF);
    check("commit_valid0", valid_rule_o, 32'h0000_0002);
    check("commit_conn1", {24'd0, connectivity_map_o[15:8]}, 32'h0000_000F);
    cfg_read(12'hC04, 32'd0, "rd_status_clean");

    // Drain timeout: 10 cycles of drain, no copy, sticky error
    cfg_write(12'hC08, 32'd10, 1'b0);
    cfg_write(12'h008, 32'h0000_00AA, 1'b1);
    node_idle = 1'b0;
    cfg_write(12'hC00, 32'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin m_drain = 1'b1; step(); end
    m_drain = 1'b0; step();
    cfg_read(12'hC04, 32'h0000_0006, "rd_status_tmo");
    check("tmo_no_copy", start_addr_o[95:64], 32'd0);
    cfg_write(12'hC04, 32'd0, 1'b0);
    cfg_read(12'hC04, 32'h0000_0004, "rd_status_tmo_clr");

    // Delayed idle, STATUS read and held shadow write during DRAIN
    cfg_write(12'hC08, 32'd0, 1'b0);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 12'hC00; cfg_wdata = 32'd1;
    #1; check("ctrl_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    step();
    m_drain = 1'b1; cfg_we = 1'b0; cfg_addr = 12'hC04;
    #1; check("drain_rd_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    step();
    check("drain_rd_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
    check("drain_rd_status", cfg_rdata_o, 32'h0000_0005);
    cfg_we = 1'b1; cfg_addr = 12'h00C; cfg_wdata = 32'h0000_0033;
    for (int c = 2; c < 8; c++) begin
      m_drain = 1'b1;
      if (c == 6) node_idle = 1'b1;
      #1; check("held_wr_gnt", {31'd0, cfg_gnt_o}, 32'd0);
      step();
    end
    m_drain = 1'b0; model_commit();
    #1; check("held_wr_lands_gnt", {31'd0, cfg_gnt_o}, 32'd1);
    model_write(12'h00C, 32'h0000_0033);
    step();
    cfg_req = 1'b0; cfg_we = 1'b0;
    check("late_commit_start2", start_addr_o[95:64], 32'h0000_00AA);
    check("late_commit_start3", start_addr_o[127:96], 32'd0);
    cfg_read(12'h00C, 32'h0000_0033, "rd_held_wr");
    cfg_read(12'hC04, 32'h0000_0004, "rd_status_after_held");

    // Reset in the middle of DRAIN
    node_idle = 1'b0;
    cfg_write(12'hC00, 32'd1, 1'b0);
    m_drain = 1'b1; step();
    m_drain = 1'b1; step();
    m_drain = 1'b1; rst = 1'b1; step();
    m_drain = 1'b0; model_reset(); rst = 1'b0; node_idle = 1'b1;
    check("rst_drain_drop", {31'd0, drain_req_o}, 32'd0);
    check("rst_start2", start_addr_o[95:64], 32'd0);
    cfg_read(12'h008, 32'd0, "rd_start2_rst");
    cfg_read(12'hA00, 32'h0000_00FF, "rd_conn0_rst");
    cfg_read(12'hC04, 32'd0, "rd_status_rst2");
    cfg_read(12'hC08, 32'h0000_FFFF, "rd_timeout_rst2");

`ifdef AXI_NODE_CFG_LOCK_EN
    // Locked: writes granted but ignored, no commit starts
    cfg_write(12'hC00, 32'd2, 1'b0);
    cfg_write(12'h000, 32'd5, 1'b0);
    cfg_write(12'hC00, 32'd1, 1'b0);
    for (int k = 0; k < 4; k++) step();
    cfg_read(12'h000, 32'd0, "rd_locked_start0");
    cfg_read(12'hC04, 32'h0000_0008, "rd_status_locked");
`else
    // Without the lock feature CTRL bit1 has no effect
    cfg_write(12'hC00, 32'd2, 1'b0);
    cfg_read(12'hC04, 32'd0, "rd_status_nolock");
    cfg_read(12'hC00, 32'd0, "rd_ctrl_reads0");
    cfg_write(12'h000, 32'd5, 1'b1);
    cfg_read(12'h000, 32'd5, "rd_nolock_start0");
`endif

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
